// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: owns both scores, paces serve and post-goal pauses on frame ticks,
// and detects the end of the match.
module pong_match_ctrl #(
   parameter int unsigned WIN_SCORE    = 11,
   parameter int unsigned WIN_MARGIN   = 2,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned PAUSE_FRAMES = 30
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       frame_tick_i,
   input  logic       goal_player_1_i,
   input  logic       goal_player_2_i,
   output logic [5:0] score_player_1_o,
   output logic [5:0] score_player_2_o,
   output logic       ball_enable_o,
   output logic       ball_reset_o,
   output logic       serve_dir_o,
   output logic       game_over_o,
   output logic [1:0] winner_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      StIdle       = 3'd0,
      StServeWait  = 3'd1,
      StPlay       = 3'd2,
      StPointPause = 3'd3,
      StGameOver   = 3'd4
   } state_e;

   localparam logic [5:0]        LP_WIN_SCORE  = 6'(WIN_SCORE);
   localparam logic signed [6:0] LP_WIN_MARGIN = 7'(WIN_MARGIN);
   localparam logic [7:0]        LP_SERVE_LAST = 8'(SERVE_FRAMES - 1);
   localparam logic [7:0]        LP_PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

   state_e     r_state;
   logic [7:0] r_count;
   logic       r_start_q;
   logic [5:0] r_score_1;
   logic [5:0] r_score_2;
   logic       r_ball_enable;
   logic       r_ball_reset;
   logic       r_serve_dir;
   logic       r_game_over;
   logic [1:0] r_winner;

   logic              w_start_edge;
   logic [5:0]        w_inc_1;
   logic [5:0]        w_inc_2;
   logic signed [6:0] w_diff_1;
   logic signed [6:0] w_diff_2;
   logic              w_win_1;
   logic              w_win_2;

   assign w_start_edge = start_i & ~r_start_q;

   // Post-increment scores; only the scorer's score changes, so only the scorer can win.
   assign w_inc_1  = (r_score_1 == 6'd63) ? 6'd63 : r_score_1 + 6'd1;
   assign w_inc_2  = (r_score_2 == 6'd63) ? 6'd63 : r_score_2 + 6'd1;
   assign w_diff_1 = $signed({1'b0, w_inc_1}) - $signed({1'b0, r_score_2});
   assign w_diff_2 = $signed({1'b0, w_inc_2}) - $signed({1'b0, r_score_1});
   assign w_win_1  = ((w_inc_1 >= LP_WIN_SCORE) && (w_diff_1 >= LP_WIN_MARGIN)) ||
                     (w_inc_1 == 6'd63);
   assign w_win_2  = ((w_inc_2 >= LP_WIN_SCORE) && (w_diff_2 >= LP_WIN_MARGIN)) ||
                     (w_inc_2 == 6'd63);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= StIdle;
         r_count       <= 8'd0;
         r_start_q     <= 1'b0;
         r_score_1     <= 6'd0;
         r_score_2     <= 6'd0;
         r_ball_enable <= 1'b0;
         r_ball_reset  <= 1'b0;
         r_serve_dir   <= 1'b0;
         r_game_over   <= 1'b0;
         r_winner      <= 2'b00;
      end else begin
         r_start_q    <= start_i;
         r_ball_reset <= 1'b0;
         case (r_state)
            StIdle, StGameOver: begin
               if (w_start_edge) begin
                  r_score_1    <= 6'd0;
                  r_score_2    <= 6'd0;
                  r_winner     <= 2'b00;
                  r_game_over  <= 1'b0;
                  r_serve_dir  <= 1'b0;
                  r_ball_reset <= 1'b1;
                  r_count      <= 8'd0;
                  r_state      <= StServeWait;
               end
            end
            StServeWait: begin
               if (frame_tick_i) begin
                  if (r_count == LP_SERVE_LAST) begin
                     r_ball_enable <= 1'b1;
                     r_state       <= StPlay;
                  end else begin
                     r_count <= r_count + 8'd1;
                  end
               end
            end
            StPlay: begin
               if (goal_player_1_i || goal_player_2_i) begin
                  r_ball_enable <= 1'b0;
                  r_count       <= 8'd0;
                  r_state       <= StPointPause;
                  // Simultaneous goals void the rally: nothing but the state changes.
                  if (goal_player_1_i && !goal_player_2_i) begin
                     r_score_1   <= w_inc_1;
                     r_serve_dir <= 1'b1;
                     if (w_win_1) begin
                        r_winner    <= 2'b01;
                        r_game_over <= 1'b1;
                        r_state     <= StGameOver;
                     end
                  end else if (goal_player_2_i && !goal_player_1_i) begin
                     r_score_2   <= w_inc_2;
                     r_serve_dir <= 1'b0;
                     if (w_win_2) begin
                        r_winner    <= 2'b10;
                        r_game_over <= 1'b1;
                        r_state     <= StGameOver;
                     end
                  end
               end
            end
            StPointPause: begin
               if (frame_tick_i) begin
                  if (r_count == LP_PAUSE_LAST) begin
                     r_ball_reset <= 1'b1;
                     r_count      <= 8'd0;
                     r_state      <= StServeWait;
                  end else begin
                     r_count <= r_count + 8'd1;
                  end
               end
            end
            default: begin
               r_ball_enable <= 1'b0;
               r_state       <= StIdle;
            end
         endcase
      end
   end

   assign score_player_1_o = r_score_1;
   assign score_player_2_o = r_score_2;
   assign ball_enable_o    = r_ball_enable;
   assign ball_reset_o     = r_ball_reset;
   assign serve_dir_o      = r_serve_dir;
   assign game_over_o      = r_game_over;
   assign winner_o         = r_winner;
   assign state_o          = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: expected outputs are queued as stimulus is applied
// and compared once the DUT has clocked the stimulus in.
module tb_pong_match_ctrl;

   localparam int SERVE = 60;
   localparam int PAUSE = 30;

   localparam int SEL_STATE = 0;
   localparam int SEL_S1    = 1;
   localparam int SEL_S2    = 2;
   localparam int SEL_EN    = 3;
   localparam int SEL_RST   = 4;
   localparam int SEL_DIR   = 5;
   localparam int SEL_GO    = 6;
   localparam int SEL_WIN   = 7;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       start_i;
   logic       frame_tick_i;
   logic       goal_player_1_i;
   logic       goal_player_2_i;
   logic [5:0] score_player_1_o;
   logic [5:0] score_player_2_o;
   logic       ball_enable_o;
   logic       ball_reset_o;
   logic       serve_dir_o;
   logic       game_over_o;
   logic [1:0] winner_o;
   logic [2:0] state_o;

   pong_match_ctrl #(
      .WIN_SCORE   (11),
      .WIN_MARGIN  (2),
      .SERVE_FRAMES(SERVE),
      .PAUSE_FRAMES(PAUSE)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .start_i         (start_i),
      .frame_tick_i    (frame_tick_i),
      .goal_player_1_i (goal_player_1_i),
      .goal_player_2_i (goal_player_2_i),
      .score_player_1_o(score_player_1_o),
      .score_player_2_o(score_player_2_o),
      .ball_enable_o   (ball_enable_o),
      .ball_reset_o    (ball_reset_o),
      .serve_dir_o     (serve_dir_o),
      .game_over_o     (game_over_o),
      .winner_o        (winner_o),
      .state_o         (state_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string tag;
      int    sel;
      int    exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_s1    = 0;
   int   m_s2    = 0;
   int   m_dir   = 0;

   function automatic int observe(input int sel);
      case (sel)
         SEL_STATE: return int'(state_o);
         SEL_S1:    return int'(score_player_1_o);
         SEL_S2:    return int'(score_player_2_o);
         SEL_EN:    return int'(ball_enable_o);
         SEL_RST:   return int'(ball_reset_o);
         SEL_DIR:   return int'(serve_dir_o);
         SEL_GO:    return int'(game_over_o);
         SEL_WIN:   return int'(winner_o);
         default:   return -1;
      endcase
   endfunction

   function automatic bit wins(input int a, input int b);
      return ((a >= 11) && (a - b >= 2)) || (a == 63);
   endfunction

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_exp(input string tag, input int sel, input int exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick_i = 1'b1;
         step();
         frame_tick_i = 1'b0;
      end
   endtask

   task automatic push_scores(input string tag);
      push_exp({tag, "_s1"}, SEL_S1, m_s1);
      push_exp({tag, "_s2"}, SEL_S2, m_s2);
   endtask

   task automatic serve_to_play();
      ticks(SERVE - 1);
      push_exp("serve_hold", SEL_STATE, 1);
      push_exp("serve_hold_en", SEL_EN, 0);
      drain();
      ticks(1);
      push_exp("play_state", SEL_STATE, 2);
      push_exp("play_en", SEL_EN, 1);
      drain();
   endtask

   task automatic goal(input bit a, input bit b);
      bit win;
      goal_player_1_i = a;
      goal_player_2_i = b;
      step();
      goal_player_1_i = 1'b0;
      goal_player_2_i = 1'b0;
      win = 1'b0;
      if (a && !b) begin
         m_s1  = (m_s1 == 63) ? 63 : m_s1 + 1;
         m_dir = 1;
         win   = wins(m_s1, m_s2);
      end else if (b && !a) begin
         m_s2  = (m_s2 == 63) ? 63 : m_s2 + 1;
         m_dir = 0;
         win   = wins(m_s2, m_s1);
      end
      push_scores("goal");
      push_exp("goal_dir", SEL_DIR, m_dir);
      push_exp("goal_en", SEL_EN, 0);
      push_exp("goal_state", SEL_STATE, win ? 4 : 3);
      push_exp("goal_over", SEL_GO, win ? 1 : 0);
      push_exp("goal_winner", SEL_WIN, win ? (a ? 1 : 2) : 0);
      drain();
   endtask

   task automatic pause_to_serve();
      ticks(PAUSE - 1);
      push_exp("pause_hold", SEL_STATE, 3);
      drain();
      ticks(1);
      push_exp("pause_exit_state", SEL_STATE, 1);
      push_exp("pause_exit_rst", SEL_RST, 1);
      drain();
      step();
      push_exp("pause_rst_width", SEL_RST, 0);
      drain();
   endtask

   // Goals and a start edge that must all be ignored outside PLAY/IDLE/GAME_OVER.
   task automatic disturb();
      goal_player_1_i = 1'b1;
      step();
      goal_player_1_i = 1'b0;
      goal_player_2_i = 1'b1;
      step();
      goal_player_2_i = 1'b0;
      start_i = 1'b0;
      step();
      start_i = 1'b1;
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_i           = 1'b1;
      start_i         = 1'b0;
      frame_tick_i    = 1'b0;
      goal_player_1_i = 1'b0;
      goal_player_2_i = 1'b0;
      step();
      step();
      push_exp("rst_state", SEL_STATE, 0);
      push_scores("rst");
      push_exp("rst_en", SEL_EN, 0);
      push_exp("rst_ballrst", SEL_RST, 0);
      push_exp("rst_dir", SEL_DIR, 0);
      push_exp("rst_over", SEL_GO, 0);
      push_exp("rst_winner", SEL_WIN, 0);
      drain();
      rst_i = 1'b0;
      step();

      start_i = 1'b1;
      step();
      push_exp("start_state", SEL_STATE, 1);
      push_exp("start_ballrst", SEL_RST, 1);
      push_exp("start_dir", SEL_DIR, 0);
      drain();
      step();
      push_exp("start_rst_width", SEL_RST, 0);
      drain();

      serve_to_play();
      goal(1'b1, 1'b0);
      pause_to_serve();

      serve_to_play();
      goal(1'b1, 1'b1);
      pause_to_serve();

      // Disturbance mid-serve: still exactly SERVE ticks to reach PLAY.
      ticks(30);
      disturb();
      push_exp("sw_ign_state", SEL_STATE, 1);
      push_scores("sw_ign");
      drain();
      ticks(SERVE - 31);
      push_exp("sw_ign_hold", SEL_STATE, 1);
      drain();
      ticks(1);
      push_exp("sw_ign_play", SEL_STATE, 2);
      drain();

      goal(1'b0, 1'b1);
      ticks(10);
      disturb();
      push_exp("pp_ign_state", SEL_STATE, 3);
      push_scores("pp_ign");
      drain();
      ticks(PAUSE - 11);
      push_exp("pp_ign_hold", SEL_STATE, 3);
      drain();
      ticks(1);
      push_exp("pp_ign_exit", SEL_STATE, 1);
      push_exp("pp_ign_rst", SEL_RST, 1);
      drain();
      step();

      for (int i = 0; i < 9; i++) begin
         serve_to_play();
         goal(1'b1, 1'b0);
         pause_to_serve();
         serve_to_play();
         goal(1'b0, 1'b1);
         pause_to_serve();
      end

      serve_to_play();
      goal(1'b1, 1'b0);
      pause_to_serve();
      serve_to_play();
      goal(1'b1, 1'b0);

      start_i = 1'b0;
      step();
      start_i = 1'b1;
      step();
      m_s1  = 0;
      m_s2  = 0;
      m_dir = 0;
      push_scores("restart");
      push_exp("restart_winner", SEL_WIN, 0);
      push_exp("restart_over", SEL_GO, 0);
      push_exp("restart_dir", SEL_DIR, 0);
      push_exp("restart_state", SEL_STATE, 1);
      push_exp("restart_ballrst", SEL_RST, 1);
      drain();
      step();

      serve_to_play();
      goal(1'b0, 1'b1);
      pause_to_serve();
      serve_to_play();

      rst_i = 1'b1;
      #2;
      m_s2 = 0;
      push_exp("async_state", SEL_STATE, 0);
      push_scores("async");
      push_exp("async_en", SEL_EN, 0);
      push_exp("async_dir", SEL_DIR, 0);
      drain();
      rst_i = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match sequencer for the pong game.
- Owns both players' 6-bit scores and drives them to the score overlay renderer.
- Gates and re-centres the ball via serve timing, and detects the end of the match.
- Sits between the ball/paddle collision logic, which reports goals, and the video pipeline, which supplies frame ticks and consumes scores.

Parameters:
- WIN_SCORE, 11: minimum score required to win (1..63).
- WIN_MARGIN, 2: required lead over opponent at or above WIN_SCORE (1..63).
- SERVE_FRAMES, 60: frame ticks the ball is held centred before launch (1..255).
- PAUSE_FRAMES, 30: frame ticks of post-goal pause before the serve wait (1..255).

Ports:
- clk_i  input  1  pixel clock.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  start button level, already synchronised; rising edge detected internally.
- frame_tick_i  input  1  one-cycle pulse per frame (start of vblank).
- goal_player_1_i  input  1  one-cycle pulse: player 1 scored.
- goal_player_2_i  input  1  one-cycle pulse: player 2 scored.
- score_player_1_o  output  6  player 1 score, registered.
- score_player_2_o  output  6  player 2 score, registered.
- ball_enable_o  output  1  ball may move; high only in PLAY.
- ball_reset_o  output  1  one-cycle pulse: re-centre ball.
- serve_dir_o  output  1  0 = launch toward player 1, 1 = toward player 2.
- game_over_o  output  1  high in GAME_OVER.
- winner_o  output  2  2'b01 = player 1, 2'b10 = player 2, 2'b00 = none.
- state_o  output  3  current state encoding, for debug.

Behaviour:
- Reset (async, active-high), all outputs and registers:
  - state = IDLE, both scores = 0, frame counter = 0, start edge register = 0.
  - ball_enable_o = 0, ball_reset_o = 0, serve_dir_o = 0, game_over_o = 0, winner_o = 0.
- Start edge: start_edge = start_i & ~start_q, where start_q is start_i registered.
- IDLE (0):
  - On start_edge: clear scores, set serve_dir_o = 0, pulse ball_reset_o, go to SERVE_WAIT.
- SERVE_WAIT (1):
  - Counter clears on entry.
  - Counter increments on each frame_tick_i.
  - On the tick where counter == SERVE_FRAMES-1, go to PLAY.
- PLAY (2):
  - ball_enable_o = 1.
  - Goals are counted only in this state; goals in any other state are ignored.
- Goal by player N in PLAY at cycle T, at edge T+1:
  - Score N increments, saturating at 63.
  - serve_dir_o points toward the conceding player (p1 goal gives 1; p2 goal gives 0).
  - Win is evaluated on the post-increment values, in the same cycle.
  - Winner found: go to GAME_OVER, set winner_o, set game_over_o.
  - Otherwise: go to POINT_PAUSE.
  - ball_enable_o is low from T+1.
- Both goal pulses in the same cycle in PLAY:
  - Neither score changes and serve_dir_o is unchanged.
  - Go to POINT_PAUSE (void rally).
- Win rule: player N wins when score_N >= WIN_SCORE and score_N - score_other >= WIN_MARGIN.
  - A score reaching 63 also wins unconditionally, as a deadlock guard.
  - Differences are computed in 7-bit signed arithmetic.
- POINT_PAUSE (3):
  - Counter clears on entry.
  - After PAUSE_FRAMES ticks (same counting rule as SERVE_WAIT), pulse ball_reset_o and go to SERVE_WAIT.
- GAME_OVER (4):
  - Scores are held and ball_enable_o = 0.
  - On start_edge: clear scores, clear winner_o and game_over_o, set serve_dir_o = 0, pulse ball_reset_o, go to SERVE_WAIT.
- start_edge in SERVE_WAIT, PLAY or POINT_PAUSE is ignored (no mid-match restart).
- ball_reset_o is exactly one cycle wide, asserted on the edge that enters SERVE_WAIT.
- Encodings 5..7 are unreachable; if ever entered, the next edge goes to IDLE.
- Reset mid-match: immediate return to the reset state; scores are lost.

Test Plan:
- Reset, then start_i rising:
  - ball_reset_o pulses 1 cycle and state_o = 1.
  - After 60 frame_tick_i pulses, state_o = 2 and ball_enable_o = 1.
- In PLAY, pulse goal_player_1_i:
  - Next cycle: score_player_1_o = 1, serve_dir_o = 1, state_o = 3.
  - After 30 ticks: ball_reset_o pulse, state_o = 1.
- Deuce play: drive the score to 10-10, then p1 goal (11-10):
  - No win; state_o = 3.
  - Next p1 goal (12-10): game_over_o = 1, winner_o = 2'b01, ball_enable_o = 0.
- Simultaneous goal_player_1_i and goal_player_2_i in PLAY:
  - Scores unchanged and serve_dir_o unchanged; state_o = 3.
- Goal pulses and start_i edges during SERVE_WAIT and POINT_PAUSE:
  - Scores, state and counter progression are unaffected.
- In GAME_OVER, start_i rising:
  - Scores become 0, winner_o = 0, game_over_o = 0, serve_dir_o = 0, state_o = 1.
  - Then assert rst_i mid-PLAY: all outputs return to reset values asynchronously.
